score_display: RTL and testbench

//  Downstream consumer of the breakout game core's brick-hit events.

---
 rtl/score_display.sv | 134 +++++++++++++
 tb/tb_score_display.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// rtl/score_display.sv - two-digit BCD brick-hit score with multiplexed active-low 7-segment driver
module score_display #(
  parameter int SCAN_DIV      = 25000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       clr,
  input  logic       score_inc,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       maxed
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    SEL_ONES = 1'b0,
    SEL_TENS = 1'b1
  } sel_e;

  logic          inc_q,      inc_d;
  logic [3:0]    ones_q,     ones_d;
  logic [3:0]    tens_q,     tens_d;
  logic          maxed_q,    maxed_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  sel_e          sel_q,      sel_d;
  logic [1:0]    digit_en_q, digit_en_d;
  logic [6:0]    seg_q,      seg_d;
  logic          hit;
  logic          at_max;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0000001;
      4'd1:    g = 7'b1001111;
      4'd2:    g = 7'b0010010;
      4'd3:    g = 7'b0000110;
      4'd4:    g = 7'b1001100;
      4'd5:    g = 7'b0100100;
      4'd6:    g = 7'b0100000;
      4'd7:    g = 7'b0001111;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0000100;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  always_comb begin
    inc_d      = score_inc;
    ones_d     = ones_q;
    tens_d     = tens_q;
    maxed_d    = maxed_q;
    scan_cnt_d = scan_cnt_q;
    sel_d      = sel_q;
    digit_en_d = 2'b01;
    seg_d      = SEG_BLANK;

    // A held strobe counts once: only the rising edge is a hit.
    hit    = score_inc & ~inc_q;
    at_max = (ones_q == 4'd9) && (tens_q == 4'd9);

    if (clr) begin
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      maxed_d = 1'b0;
    end else if (hit && !at_max) begin
      if (ones_q != 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end
      if ((tens_q == 4'd9) && (ones_q == 4'd8)) begin
        maxed_d = 1'b1;
      end
    end

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      sel_d      = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
    end else begin
      scan_cnt_d = scan_cnt_q + CW'(1);
    end

    // Output stage follows the current slot and score with one cycle of latency.
    if (sel_q == SEL_ONES) begin
      digit_en_d = 2'b01;
      seg_d      = glyph(ones_q);
    end else begin
      digit_en_d = 2'b10;
      if (BLANK_LEADING && (tens_q == 4'd0)) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = glyph(tens_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      inc_q      <= 1'b0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      maxed_q    <= 1'b0;
      scan_cnt_q <= '0;
      sel_q      <= SEL_ONES;
      digit_en_q <= 2'b01;
      seg_q      <= 7'b0000001;
    end else begin
      inc_q      <= inc_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      maxed_q    <= maxed_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
      digit_en_q <= digit_en_d;
      seg_q      <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign digit_en   = digit_en_q;
  assign score_ones = ones_q;
  assign score_tens = tens_q;
  assign maxed      = maxed_q;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - directed self-checking bench for score_display with SCAN_DIV=4
module tb_score_display;

  localparam logic [6:0] G0    = 7'b0000001;
  localparam logic [6:0] G1    = 7'b1001111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       score_inc;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic       maxed;

  int checks   = 0;
  int failures = 0;
  int since_rst = 0;

  score_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .CLK        (clk),
    .reset      (reset),
    .clr        (clr),
    .score_inc  (score_inc),
    .seg        (seg),
    .digit_en   (digit_en),
    .score_ones (score_ones),
    .score_tens (score_tens),
    .maxed      (maxed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot selected after k edges since reset (4 edges per slot).
  function automatic logic exp_sel(input int k);
    return ((k / 4) % 2) == 1;
  endfunction

  function automatic logic [1:0] exp_den(input int k);
    if (k == 0) return 2'b01;
    return exp_sel(k - 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset) since_rst = 0;
    else        since_rst++;
  endtask

  task automatic pulse();
    score_inc = 1'b1;
    tick();
    score_inc = 1'b0;
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (digit_en !== 2'b01) begin failures++; $display("FAIL reset_digit_en got=%b exp=01", digit_en); end
    checks++;
    if (seg !== G0) begin failures++; $display("FAIL reset_seg got=%b exp=%b", seg, G0); end
    checks++;
    if (score_ones !== 4'd0 || score_tens !== 4'd0) begin
      failures++; $display("FAIL reset_score got=%0d%0d exp=00", score_tens, score_ones);
    end
    checks++;
    if (maxed !== 1'b0) begin failures++; $display("FAIL reset_maxed got=%b exp=0", maxed); end
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (digit_en !== exp_den(since_rst)) begin
        failures++; $display("FAIL scan_toggle k=%0d got=%b exp=%b", k, digit_en, exp_den(since_rst));
      end
    end
  endtask

  task automatic test_edge_count();
    do_clr();
    for (int r = 0; r < 3; r++) begin
      score_inc = 1'b1;
      tick();
      checks++;
      if (score_ones !== 4'(r + 1) || score_tens !== 4'd0) begin
        failures++; $display("FAIL edge_rise r=%0d got=%0d%0d exp=0%0d", r, score_tens, score_ones, r + 1);
      end
      repeat (9) tick();
      checks++;
      if (score_ones !== 4'(r + 1) || score_tens !== 4'd0) begin
        failures++; $display("FAIL edge_held r=%0d got=%0d%0d exp=0%0d", r, score_tens, score_ones, r + 1);
      end
      score_inc = 1'b0;
      tick();
    end
  endtask

  task automatic test_carry_blank();
    do_clr();
    repeat (9) pulse();
    checks++;
    if (score_tens !== 4'd0 || score_ones !== 4'd9) begin
      failures++; $display("FAIL carry_09 got=%0d%0d exp=09", score_tens, score_ones);
    end
    for (int i = 0; i < 10 && !exp_sel(since_rst - 1); i++) tick();
    checks++;
    if (digit_en !== 2'b10 || seg !== BLANK) begin
      failures++; $display("FAIL blank_tens got den=%b seg=%b exp den=10 seg=%b", digit_en, seg, BLANK);
    end
    pulse();
    checks++;
    if (score_tens !== 4'd1 || score_ones !== 4'd0) begin
      failures++; $display("FAIL carry_10 got=%0d%0d exp=10", score_tens, score_ones);
    end
    tick();
    for (int i = 0; i < 10 && !exp_sel(since_rst - 1); i++) tick();
    checks++;
    if (digit_en !== 2'b10 || seg !== G1) begin
      failures++; $display("FAIL tens_glyph got den=%b seg=%b exp den=10 seg=%b", digit_en, seg, G1);
    end
    for (int i = 0; i < 10 && exp_sel(since_rst - 1); i++) tick();
    checks++;
    if (digit_en !== 2'b01 || seg !== G0) begin
      failures++; $display("FAIL ones_glyph got den=%b seg=%b exp den=01 seg=%b", digit_en, seg, G0);
    end
  endtask

  task automatic test_saturate();
    int s;
    do_clr();
    for (int i = 1; i <= 105; i++) begin
      pulse();
      s = (i > 99) ? 99 : i;
      checks++;
      if (score_tens !== 4'(s / 10) || score_ones !== 4'(s % 10) || maxed !== (i >= 99)) begin
        failures++;
        $display("FAIL saturate i=%0d got=%0d%0d maxed=%b exp=%0d maxed=%b",
                 i, score_tens, score_ones, maxed, s, (i >= 99));
      end
    end
  endtask

  task automatic test_clr_vs_hit();
    do_clr();
    repeat (42) pulse();
    checks++;
    if (score_tens !== 4'd4 || score_ones !== 4'd2) begin
      failures++; $display("FAIL clr_pre got=%0d%0d exp=42", score_tens, score_ones);
    end
    clr = 1'b1;
    score_inc = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (score_tens !== 4'd0 || score_ones !== 4'd0 || maxed !== 1'b0) begin
      failures++; $display("FAIL clr_wins got=%0d%0d maxed=%b exp=00 maxed=0", score_tens, score_ones, maxed);
    end
    tick();
    checks++;
    if (score_ones !== 4'd0) begin
      failures++; $display("FAIL clr_inc_tracked got=%0d exp=0", score_ones);
    end
    score_inc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (digit_en !== exp_den(since_rst)) begin
        failures++; $display("FAIL clr_scan k=%0d got=%b exp=%b", k, digit_en, exp_den(since_rst));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_clr();
    repeat (57) pulse();
    checks++;
    if (score_tens !== 4'd5 || score_ones !== 4'd7) begin
      failures++; $display("FAIL mid_pre got=%0d%0d exp=57", score_tens, score_ones);
    end
    for (int i = 0; i < 10 && !(exp_sel(since_rst) && (since_rst % 4) == 1); i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (score_tens !== 4'd0 || score_ones !== 4'd0 || maxed !== 1'b0 || digit_en !== 2'b01 || seg !== G0) begin
      failures++;
      $display("FAIL mid_reset got=%0d%0d maxed=%b den=%b seg=%b exp=00 maxed=0 den=01 seg=%b",
               score_tens, score_ones, maxed, digit_en, seg, G0);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (digit_en !== exp_den(since_rst)) begin
        failures++; $display("FAIL mid_scan k=%0d got=%b exp=%b", k, digit_en, exp_den(since_rst));
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    clr       = 1'b0;
    score_inc = 1'b0;
    test_reset();
    test_edge_count();
    test_carry_blank();
    test_saturate();
    test_clr_vs_hit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
